toggle_event_rx: RTL and testbench
==================================

# toggle_event_rx

Receiver end of the toggle-signalling link: a transmitter toggle flip-flop flips one wire per event, and this block recovers those events in the local clock domain. It synchronises the asynchronous toggle line and turns each level change into a one-cycle pulse. It queues events in a saturating pending counter drained by a valid/ready handshake, and keeps a wrapping total-event count. It sits at the clock-domain boundary between the toggle transmitter and the local consumer logic.

## Interface
- SYNC_STAGES, 2, synchroniser depth; legal values ≥ 2.
- CNT_W, 8, width of `evt_count`.
- PEND_W, 3, width of `pending`; capacity MAX_PEND = 2^PEND_W − 1.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- tog_in  in  1  asynchronous toggle line; each level change is one event.
- evt_ready  in  1  consumer accepts one pending event.
- clr_ovf  in  1  synchronous clear of `overflow`.
- evt_pulse  out  1  one-cycle pulse per detected toggle.
- evt_valid  out  1  high when `pending != 0`.
- pending  out  PEND_W  number of queued, unconsumed events.
- evt_count  out  CNT_W  total toggles detected; wraps modulo 2^CNT_W.
- overflow  out  1  sticky flag: an event arrived while the queue was full.
- ack_tog  out  1  acknowledge toggle sent back to the transmitter (see Configuration).

## Operation
- Synchroniser: `sync[0..SYNC_STAGES-1]` shift register fed by `tog_in`, followed by `prev`, a one-stage delay of the last stage.
- Event detect: `edge = sync[last] ^ prev`.
- On `edge`, at one clock edge:
  - `evt_pulse` is registered high for the next cycle;
  - `evt_count` increments;
  - the queue is pushed.
- Pop occurs when `evt_valid && evt_ready`.
- Queue update per cycle:
  - push only: `pending + 1`;
  - pop only: `pending − 1`;
  - push and pop together: `pending` unchanged;
  - neither: unchanged.
- Full queue: `pending == MAX_PEND` with a push and no pop → `pending` holds, the event is dropped, `overflow` is set. `evt_count` and `evt_pulse` still reflect the dropped event.
- Full queue with simultaneous push and pop: `pending` unchanged, `overflow` not set.
- Empty queue: `evt_ready` has no effect when `evt_valid = 0`, and `pending` never underflows.
- `overflow` stays set until `clr_ovf`. If a set condition and `clr_ovf` occur in the same cycle, set wins.
- Reset values: all sync stages, `prev`, `evt_pulse`, `pending`, `evt_count`, `overflow` and `ack_tog` are 0, so `evt_valid = 0`.
- Reset is honoured mid-operation: any queued events are discarded.
- Because reset clears the chain to 0, a `tog_in = 1` at reset release counts as one event. The transmitter must reset its toggle to 0.

## Timing
- Latency: for a `tog_in` change captured by `sync[0]` at edge E0, `evt_pulse` is high during the cycle after edge E0+SYNC_STAGES. `pending` and `evt_count` update at that same edge.
- Consecutive toggles are each detected, provided every level is held for at least 2 clk periods at `tog_in`. A level shorter than one period may be missed; this is not an error case.
- `evt_valid`, `pending`, `overflow` and `evt_count` are registered outputs with no combinational path from inputs.
- `evt_valid` reflects `pending` in the same cycle; a pop takes effect at the next edge.

## Configuration
- `TOG_RX_ACK_EN` defined: `ack_tog` toggles on every pop, registered at the pop edge, reset 0. This gives the transmitter a closed 2-phase handshake.
- `TOG_RX_ACK_EN` undefined: `ack_tog` is tied to 0 and the acknowledge register is not built. All other behaviour is identical.

## Test plan
- Reset then a single toggle, with SYNC_STAGES=2: assert/release `reset_n` with `tog_in=0`, then `tog_in`: 0→1 captured at edge E0 → `evt_pulse` high one cycle after edge E0+2; `pending=1`, `evt_valid=1`, `evt_count=1`.
- Drain: with `pending=3`, hold `evt_ready=1` → `pending` steps 3,2,1,0 on consecutive edges and `evt_valid` drops. With `TOG_RX_ACK_EN`, `ack_tog` toggles 3 times (0→1→0→1).
- Overflow: send 8 toggles 4 cycles apart with `evt_ready=0` and PEND_W=3 → `pending=7`, `evt_count=8`, `overflow=1`. Assert `clr_ovf` → `overflow=0`, `pending` still 7.
- Simultaneous events: at `pending=7`, a toggle arrives in the same cycle as a pop → `pending` stays 7, `overflow` stays 0, `evt_count` increments. At `pending=2`, push and pop together → `pending` stays 2.
- Wrap and reset mid-operation: 256 toggles with CNT_W=8 → `evt_count` returns to 0. Then pulse `reset_n` low asynchronously while `pending=4` → all outputs read 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/toggle_event_rx.sv
// toggle_event_rx: recovers toggle-line events into a pulse, a pending queue and a count.
// Optional macro TOG_RX_ACK_EN builds the ack_tog return toggle.
module toggle_event_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tog_in,
    input  logic              evt_ready,
    input  logic              clr_ovf,
    output logic              evt_pulse,
    output logic              evt_valid,
    output logic [PEND_W-1:0] pending,
    output logic [CNT_W-1:0]  evt_count,
    output logic              overflow,
    output logic              ack_tog
);

    localparam logic [PEND_W-1:0] MAX_PEND = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   pulse_q, pulse_d;
    logic [PEND_W-1:0]      pend_q, pend_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;

    logic evt_edge;
    logic push;
    logic pop;
    logic full;
    logic drop;

    assign evt_edge = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign push     = evt_edge;
    assign pop      = (pend_q != '0) && evt_ready;
    assign full     = (pend_q == MAX_PEND);
    // A push into a full queue with no pop to make room is lost.
    assign drop     = push && !pop && full;

    // Synchroniser chain and the delayed copy used for level-change detection.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], tog_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Pulse and wrapping count follow every detected change, dropped or not.
    always_comb begin
        pulse_d = evt_edge;
        cnt_d   = cnt_q;
        if (evt_edge) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Saturating pending counter; push and pop together cancel out.
    always_comb begin
        pend_d = pend_q;
        if (push && !pop && !full) begin
            pend_d = pend_q + PEND_ONE;
        end else if (pop && !push) begin
            pend_d = pend_q - PEND_ONE;
        end
    end

    // Sticky overflow; a new drop beats a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            pend_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef TOG_RX_ACK_EN
    logic ack_q, ack_d;

    // Return toggle flips once per consumed event.
    always_comb begin
        ack_d = ack_q ^ pop;
    end

    // Acknowledge register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
        end
    end

    assign ack_tog = ack_q;
`else
    assign ack_tog = 1'b0;
`endif

    assign evt_pulse = pulse_q;
    assign evt_valid = (pend_q != '0);
    assign pending   = pend_q;
    assign evt_count = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_toggle_event_rx.sv
// tb_toggle_event_rx: directed checks of toggle_event_rx with default parameters.
// Expected ack_tog follows TOG_RX_ACK_EN when that macro is defined.
module tb_toggle_event_rx;

    logic       clk;
    logic       reset_n;
    logic       tog_in;
    logic       evt_ready;
    logic       clr_ovf;
    logic       evt_pulse;
    logic       evt_valid;
    logic [2:0] pending;
    logic [7:0] evt_count;
    logic       overflow;
    logic       ack_tog;

    int n_checks;
    int n_errors;
    int pops;

    toggle_event_rx #(
        .SYNC_STAGES(2),
        .CNT_W(8),
        .PEND_W(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .tog_in(tog_in),
        .evt_ready(evt_ready),
        .clr_ovf(clr_ovf),
        .evt_pulse(evt_pulse),
        .evt_valid(evt_valid),
        .pending(pending),
        .evt_count(evt_count),
        .overflow(overflow),
        .ack_tog(ack_tog)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send();
        tog_in = ~tog_in;
        repeat (4) tick();
    endtask

    function automatic int exp_ack();
`ifdef TOG_RX_ACK_EN
        return pops & 1;
`else
        return 0;
`endif
    endfunction

    // Push and pop land on the same edge: pop enabled only for the edge cycle.
    task automatic send_with_pop();
        tog_in = ~tog_in;
        repeat (2) tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        pops++;
        tick();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        pops      = 0;
        reset_n   = 1'b0;
        tog_in    = 1'b0;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        repeat (3) tick();
        check("rst_pulse", evt_pulse, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_pend", pending, 0);
        check("rst_cnt", evt_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ack", ack_tog, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // single toggle latency
        tog_in = 1'b1;
        tick();
        check("lat_e0", evt_pulse, 0);
        tick();
        check("lat_e1", evt_pulse, 0);
        check("lat_e1_pend", pending, 0);
        tick();
        check("lat_e2", evt_pulse, 1);
        check("lat_pend", pending, 1);
        check("lat_valid", evt_valid, 1);
        check("lat_cnt", evt_count, 1);
        tick();
        check("lat_e3", evt_pulse, 0);

        // build to three and drain
        send();
        send();
        check("fill3", pending, 3);
        check("cnt3", evt_count, 3);
        evt_ready = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            tick();
            pops++;
            check("drain", pending, i);
            check("drain_ack", ack_tog, exp_ack());
        end
        check("drain_valid", evt_valid, 0);
        tick();
        check("underflow", pending, 0);
        evt_ready = 1'b0;

        // overflow
        for (int i = 0; i < 7; i++) send();
        check("ovf_pre", overflow, 0);
        check("pend7", pending, 7);
        send();
        check("ovf_pend", pending, 7);
        check("ovf_cnt", evt_count, 11);
        check("ovf_set", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_clr", overflow, 0);
        check("clr_pend", pending, 7);

        // drop and clear in the same cycle: drop wins
        tog_in = ~tog_in;
        repeat (2) tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("setwin", overflow, 1);
        check("setwin_cnt", evt_count, 12);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_clr2", overflow, 0);

        // push and pop together at full
        send_with_pop();
        check("sim7_pend", pending, 7);
        check("sim7_ovf", overflow, 0);
        check("sim7_cnt", evt_count, 13);
        check("sim7_ack", ack_tog, exp_ack());

        // down to two, then push and pop together
        evt_ready = 1'b1;
        repeat (5) begin
            tick();
            pops++;
        end
        evt_ready = 1'b0;
        check("pend2", pending, 2);
        send_with_pop();
        check("sim2_pend", pending, 2);
        check("sim2_cnt", evt_count, 14);
        check("sim2_ack", ack_tog, exp_ack());

        // count wrap
        for (int i = 0; i < 241; i++) send();
        check("cnt255", evt_count, 255);
        send();
        check("wrap", evt_count, 0);
        check("wrap_pend", pending, 7);

        // asynchronous reset with four queued
        evt_ready = 1'b1;
        repeat (3) begin
            tick();
            pops++;
        end
        evt_ready = 1'b0;
        check("pend4", pending, 4);
        check("pre_rst_ack", ack_tog, exp_ack());
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_pend", pending, 0);
        check("arst_valid", evt_valid, 0);
        check("arst_cnt", evt_count, 0);
        check("arst_ovf", overflow, 0);
        check("arst_pulse", evt_pulse, 0);
        check("arst_ack", ack_tog, 0);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        check("post_pend", pending, 0);
        check("post_cnt", evt_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
